// File: rtl/bar_shift_out.sv
// bar_shift_out: serial transmitter for a 74HC595-style shift-register chain.
// A parallel word is taken on a valid/ready handshake and shifted out MSB- or LSB-first
// on a divided serial clock. A latch strobe then moves the word onto the chain outputs.
module bar_shift_out #(
    parameter int WIDTH     = 32,
    parameter int CLKDIV    = 2,
    parameter int LSB_FIRST = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sdo,
    output logic             sclk,
    output logic             latch,
    output logic             busy
);

    localparam int unsigned DW = $clog2(CLKDIV + 1);
    localparam int unsigned BW = $clog2(WIDTH + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOW   = 2'd1,
        HIGH  = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [DW-1:0]    div;
    logic [BW-1:0]    bitcnt;
    logic [WIDTH-1:0] shreg_next;
    logic             div_done;

    // Bit that goes on the wire next, taken from the end selected by LSB_FIRST.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
    endfunction

    // Shift direction follows the transmit order; the phase ends on the last divider count.
    always_comb begin
        shreg_next = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);
        div_done   = (div == DIV_LAST);
    end

    // Frame sequencer. Every output is a register, so sclk and latch cannot glitch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            shreg     <= '0;
            div       <= '0;
            bitcnt    <= '0;
            din_ready <= 1'b0;
            sdo       <= 1'b0;
            sclk      <= 1'b0;
            latch     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    din_ready <= 1'b1;
                    sclk      <= 1'b0;
                    latch     <= 1'b0;
                    busy      <= 1'b0;
                    div       <= '0;
                    if (din_valid && din_ready) begin
                        shreg     <= din;
                        bitcnt    <= '0;
                        sdo       <= head_bit(din);
                        busy      <= 1'b1;
                        din_ready <= 1'b0;
                        state     <= LOW;
                    end
                end
                LOW: begin
                    if (div_done) begin
                        div   <= '0;
                        sclk  <= 1'b1;
                        state <= HIGH;
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                HIGH: begin
                    if (div_done) begin
                        div    <= '0;
                        sclk   <= 1'b0;
                        shreg  <= shreg_next;
                        bitcnt <= bitcnt + BW'(1);
                        if (bitcnt == BIT_LAST) begin
                            // sdo keeps the final bit through the latch phase and idle.
                            latch <= 1'b1;
                            state <= LATCH;
                        end else begin
                            sdo   <= head_bit(shreg_next);
                            state <= LOW;
                        end
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                LATCH: begin
                    if (div_done) begin
                        div       <= '0;
                        latch     <= 1'b0;
                        busy      <= 1'b0;
                        din_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bar_shift_out.sv
// tb_bar_shift_out: directed bench for bar_shift_out with a bit scoreboard per instance.
module tb_bar_shift_out;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // A: WIDTH=32 CLKDIV=2 MSB-first; B: LSB-first; C: WIDTH=8 CLKDIV=1.
    logic        a_rst, a_valid, a_ready, a_sdo, a_sclk, a_latch, a_busy;
    logic [31:0] a_din;
    logic        b_rst, b_valid, b_ready, b_sdo, b_sclk, b_latch, b_busy;
    logic [31:0] b_din;
    logic        c_rst, c_valid, c_ready, c_sdo, c_sclk, c_latch, c_busy;
    logic [7:0]  c_din;

    bar_shift_out #(.WIDTH(32), .CLKDIV(2), .LSB_FIRST(0)) u_a (
        .CLK(clk), .RST(a_rst), .din(a_din), .din_valid(a_valid), .din_ready(a_ready),
        .sdo(a_sdo), .sclk(a_sclk), .latch(a_latch), .busy(a_busy));

    bar_shift_out #(.WIDTH(32), .CLKDIV(2), .LSB_FIRST(1)) u_b (
        .CLK(clk), .RST(b_rst), .din(b_din), .din_valid(b_valid), .din_ready(b_ready),
        .sdo(b_sdo), .sclk(b_sclk), .latch(b_latch), .busy(b_busy));

    bar_shift_out #(.WIDTH(8), .CLKDIV(1), .LSB_FIRST(0)) u_c (
        .CLK(clk), .RST(c_rst), .din(c_din), .din_valid(c_valid), .din_ready(c_ready),
        .sdo(c_sdo), .sclk(c_sclk), .latch(c_latch), .busy(c_busy));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stimulus and counter reads happen 1 time unit after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Scoreboards: expected serial bits, pushed at drive time, popped at each sclk rise.
    bit qa[$];
    bit qb[$];
    bit qc[$];

    logic a_sclk_q = 1'b0, a_latch_q = 1'b0, a_hold = 1'b0;
    int   a_rises = 0, a_lpulse = 0, a_llen = 0, a_blen = 0, a_rbad = 0, a_hbad = 0, a_extra = 0;
    logic b_sclk_q = 1'b0, b_latch_q = 1'b0;
    int   b_rises = 0, b_lpulse = 0, b_extra = 0;
    logic c_sclk_q = 1'b0, c_latch_q = 1'b0;
    int   c_rises = 0, c_lpulse = 0, c_llen = 0, c_blen = 0, c_tog = 0, c_extra = 0;

    // Monitor A: bit order, sdo stability while sclk high, latch/busy widths, ready vs busy.
    always @(negedge clk) begin
        if (a_sclk && !a_sclk_q) begin
            a_rises++;
            a_hold = a_sdo;
            if (qa.size() == 0) a_extra++;
            else chk("a_bit", 32'(a_sdo), 32'(qa.pop_front()));
        end else if (a_sclk && (a_sdo !== a_hold)) begin
            a_hbad++;
        end
        if (a_latch) a_llen++;
        if (a_latch && !a_latch_q) a_lpulse++;
        if (a_busy) a_blen++;
        if (a_busy && a_ready) a_rbad++;
        a_sclk_q  = a_sclk;
        a_latch_q = a_latch;
    end

    // Monitor B: LSB-first bit order and latch pulses.
    always @(negedge clk) begin
        if (b_sclk && !b_sclk_q) begin
            b_rises++;
            if (qb.size() == 0) b_extra++;
            else chk("b_bit", 32'(b_sdo), 32'(qb.pop_front()));
        end
        if (b_latch && !b_latch_q) b_lpulse++;
        b_sclk_q  = b_sclk;
        b_latch_q = b_latch;
    end

    // Monitor C: divide-by-one timing, sclk toggles, latch/busy widths.
    always @(negedge clk) begin
        if (c_sclk && !c_sclk_q) begin
            c_rises++;
            if (qc.size() == 0) c_extra++;
            else chk("c_bit", 32'(c_sdo), 32'(qc.pop_front()));
        end
        if (c_sclk !== c_sclk_q) c_tog++;
        if (c_latch) c_llen++;
        if (c_latch && !c_latch_q) c_lpulse++;
        if (c_busy) c_blen++;
        c_sclk_q  = c_sclk;
        c_latch_q = c_latch;
    end

    task automatic push_a(input logic [31:0] w, input int nbits);
        for (int i = 31; i > 31 - nbits; i--) qa.push_back(w[i]);
    endtask

    task automatic wait_a(input int bound);
        int n = 0;
        while (a_busy && n < bound) begin step(); n++; end
        chk("a_frame_timeout", 32'(a_busy), 32'd0);
    endtask

    int r0, l0, ll0, b0, e0, h0, rb0, gap, n;

    initial begin
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
        a_din = '0; b_din = '0; c_din = '0;

        // Reset release
        repeat (3) step();
        chk("a_rst_out", 32'({a_sdo, a_sclk, a_latch, a_busy, a_ready}), 32'd0);
        chk("c_rst_out", 32'({c_sdo, c_sclk, c_latch, c_busy, c_ready}), 32'd0);
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        chk("a_ready_before_edge", 32'(a_ready), 32'd0);
        step();
        chk("a_ready_after_release", 32'(a_ready), 32'd1);
        r0 = a_rises; l0 = a_lpulse;
        repeat (5) step();
        chk("a_idle_no_rise", 32'(a_rises - r0), 32'd0);
        chk("a_idle_no_latch", 32'(a_lpulse - l0), 32'd0);
        chk("a_idle_sclk", 32'({a_sclk, a_latch, a_busy}), 32'd0);

        // MSB-first frame A500_0001
        r0 = a_rises; l0 = a_lpulse; ll0 = a_llen; b0 = a_blen; h0 = a_hbad; rb0 = a_rbad; e0 = a_extra;
        push_a(32'hA500_0001, 32);
        a_din = 32'hA500_0001; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        chk("a_first_bit", 32'(a_sdo), 32'd1);
        chk("a_busy_on_accept", 32'({a_busy, a_ready}), 32'b10);
        a_din = 32'h5A5A_5A5A;
        wait_a(400);
        chk("a_rises", 32'(a_rises - r0), 32'd32);
        chk("a_latch_pulses", 32'(a_lpulse - l0), 32'd1);
        chk("a_latch_len", 32'(a_llen - ll0), 32'd2);
        chk("a_busy_len", 32'(a_blen - b0), 32'd130);
        chk("a_sdo_hold", 32'(a_hbad - h0), 32'd0);
        chk("a_ready_during_busy", 32'(a_rbad - rb0), 32'd0);
        chk("a_extra_rises", 32'(a_extra - e0), 32'd0);
        chk("a_queue_empty", 32'(qa.size()), 32'd0);

        // Back-to-back with din_valid held; din changes mid-frame
        r0 = a_rises; l0 = a_lpulse; e0 = a_extra;
        push_a(32'h0000_0001, 32);
        push_a(32'h0000_0002, 32);
        a_din = 32'h0000_0001; a_valid = 1'b1;
        step();
        chk("a_b2b_accept1", 32'(a_busy), 32'd1);
        a_din = 32'h0000_0002;
        wait_a(400);
        gap = 0;
        while (!a_busy && gap < 20) begin gap++; step(); end
        chk("a_b2b_gap", 32'(gap), 32'd1);
        a_valid = 1'b0;
        wait_a(400);
        chk("a_b2b_rises", 32'(a_rises - r0), 32'd64);
        chk("a_b2b_latches", 32'(a_lpulse - l0), 32'd2);
        chk("a_b2b_extra", 32'(a_extra - e0), 32'd0);
        chk("a_b2b_queue", 32'(qa.size()), 32'd0);

        // Reset after the 10th sclk rise, then a full frame of ones
        step();
        r0 = a_rises; l0 = a_lpulse; e0 = a_extra;
        push_a(32'hFFFF_FFFF, 10);
        a_din = 32'hFFFF_FFFF; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        n = 0;
        while ((a_rises - r0) < 10 && n < 200) begin step(); n++; end
        chk("a_mid_tenth_rise", 32'(a_rises - r0), 32'd10);
        chk("a_mid_pre_rst", 32'({a_sdo, a_sclk, a_busy}), 32'b111);
        #1 a_rst = 1'b1;
        #1 chk("a_mid_async_out", 32'({a_sdo, a_sclk, a_latch, a_busy, a_ready}), 32'd0);
        step(); step();
        a_rst = 1'b0;
        step();
        chk("a_mid_no_latch", 32'(a_lpulse - l0), 32'd0);
        chk("a_mid_ready", 32'(a_ready), 32'd1);
        r0 = a_rises; l0 = a_lpulse;
        push_a(32'hFFFF_FFFF, 32);
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        wait_a(400);
        chk("a_ones_rises", 32'(a_rises - r0), 32'd32);
        chk("a_ones_latch", 32'(a_lpulse - l0), 32'd1);
        chk("a_ones_extra", 32'(a_extra - e0), 32'd0);
        chk("a_ones_queue", 32'(qa.size()), 32'd0);

        // LSB-first frame 0000_0003
        r0 = b_rises; l0 = b_lpulse; e0 = b_extra;
        b_din = 32'h0000_0003;
        for (int i = 0; i < 32; i++) qb.push_back(b_din[i]);
        b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        chk("b_first_bit", 32'(b_sdo), 32'd1);
        n = 0;
        while (b_busy && n < 400) begin step(); n++; end
        chk("b_frame_timeout", 32'(b_busy), 32'd0);
        chk("b_rises", 32'(b_rises - r0), 32'd32);
        chk("b_latch_pulses", 32'(b_lpulse - l0), 32'd1);
        chk("b_extra", 32'(b_extra - e0), 32'd0);
        chk("b_queue", 32'(qb.size()), 32'd0);

        // WIDTH=8 CLKDIV=1 frame 81
        r0 = c_rises; l0 = c_lpulse; ll0 = c_llen; b0 = c_blen; h0 = c_tog; e0 = c_extra;
        c_din = 8'h81;
        for (int i = 7; i >= 0; i--) qc.push_back(c_din[i]);
        c_valid = 1'b1;
        step();
        c_valid = 1'b0;
        n = 0;
        while (c_busy && n < 100) begin step(); n++; end
        chk("c_frame_timeout", 32'(c_busy), 32'd0);
        chk("c_rises", 32'(c_rises - r0), 32'd8);
        chk("c_toggles", 32'(c_tog - h0), 32'd16);
        chk("c_latch_pulses", 32'(c_lpulse - l0), 32'd1);
        chk("c_latch_len", 32'(c_llen - ll0), 32'd1);
        chk("c_busy_len", 32'(c_blen - b0), 32'd17);
        chk("c_extra", 32'(c_extra - e0), 32'd0);
        chk("c_queue", 32'(qc.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
